cache_wb_sequencer: RTL and testbench
=====================================

Name: cache_wb_sequencer

Overview:
- Sits directly downstream of the cache snoop logic. It consumes snoop / hit_modified and produces the writeback indication checked by the cache snoop assertions.
- On a snoop that hits a modified line, it reads the line out of the cache data array beat by beat and pushes it onto the memory-side writeback bus with a valid/ready handshake.
- Stalls core fetch/rd/wr traffic while a writeback is in flight.

Parameters:
- ADDR_W, 32, line address width
- DATA_W, 64, writeback beat width
- LINE_BEATS, 4, beats per cache line (power of 2, >=2)
- TIMEOUT_CYC, 256, wb_ready watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- snoop  in  1  snoop request valid this cycle
- hit_modified  in  1  snoop hit a modified line (qualified by snoop)
- snoop_addr  in  ADDR_W  line address of snoop
- fetch, rd, wr  in  1 each  core requests
- core_stall  out  1  core must hold fetch/rd/wr
- snoop_retry  out  1  snoop hit-modified refused, snoop logic must reissue
- writeback  out  1  writeback sequence active
- arr_rd_en  out  1  data array read strobe
- arr_addr  out  ADDR_W  data array line address
- arr_beat  out  $clog2(LINE_BEATS)  beat index
- arr_rdata  in  DATA_W  array data, valid 1 cycle after arr_rd_en
- wb_valid  out  1  beat valid on bus
- wb_ready  in  1  bus accepts beat
- wb_addr  out  ADDR_W  line address (stable for whole line)
- wb_data  out  DATA_W  beat data
- wb_last  out  1  final beat of line
- wb_err  out  1  one-cycle pulse, watchdog abort (optional feature)

Behaviour:
- Reset: all outputs 0, FSM IDLE, pending buffer empty, counters 0. Reset mid-line abandons the line; no further beats are issued.
- Trigger: snoop && hit_modified in IDLE. Capture snoop_addr. Next cycle: writeback=1 and FSM moves to RD. The property snoop && hit_modified |=> writeback must hold whenever snoop_retry=0.
- FSM states:
  - IDLE
  - RD: issue arr_rd_en for arr_beat.
  - WAIT: data returns from the array.
  - SEND: wb_valid held until wb_ready.
  - Loop from SEND back to RD for the next beat.
  - After the beat with wb_last=1 is accepted, go to DONE.
  - DONE: one cycle, writeback deasserts, then IDLE, or RD if the pending buffer is full.
- Beats: each beat needs at least 3 cycles (RD, WAIT, SEND with wb_ready). A line takes at least 3*LINE_BEATS+1 cycles from trigger to DONE.
- Beat counter: wraps to 0 after LINE_BEATS-1. wb_last=1 only while beat==LINE_BEATS-1 in SEND.
- Handshake: once wb_valid=1, wb_addr, wb_data and wb_last hold stable until wb_ready. wb_valid never drops without acceptance, except on reset or watchdog abort.
- Pending buffer: one entry. A snoop hit-modified while busy and buffer empty is captured there, with no retry. If busy and buffer full, snoop_retry=1 combinationally in the same cycle and the request is dropped.
- A snoop hit-modified in the DONE cycle counts as busy.
- A snoop with hit_modified=0 is ignored.
- Back-to-back lines: from DONE with buffer full, writeback stays 1 continuously and the new address loads.
- core_stall = writeback. Asserting fetch/rd/wr while stalled is legal; core_stall is never combinationally dependent on fetch/rd/wr.

Optional Feature:
- Macro: CACHE_WB_TIMEOUT_EN.
- Defined: a counter runs while in SEND with wb_ready=0. At TIMEOUT_CYC cycles:
  - wb_err pulses for 1 cycle.
  - wb_valid drops and the line is aborted.
  - FSM goes to DONE.
  - The pending entry is still processed afterwards.
- Undefined: no counter; wb_err tied 0; waits forever for wb_ready.

Decomposition:
- Package cache_wb_pkg:
  - wb_state_e enum (IDLE, RD, WAIT, SEND, DONE)
  - default width localparams
  - wb_req_t struct (addr, valid) used for the pending buffer
- One sub-module: cache_wb_pend_buf, a one-entry holding register with full flag, load, and pop.

Test Plan:
1. snoop=1, hit_modified=1, snoop_addr=0x100 in IDLE, wb_ready=1 always:
   - writeback=1 next cycle.
   - 4 beats at wb_addr=0x100, wb_last on beat 3.
   - writeback=0 after DONE; core_stall mirrors writeback.
2. Trigger with wb_ready held 0 for 5 cycles on beat 1: wb_valid/wb_data stable for all 5 cycles, beat accepted on the 6th cycle, no duplicate or skipped beat.
3. Hit-modified at 0x100, then 0x200 during beat 1, then 0x300 during beat 2:
   - 0x200 buffered, no retry.
   - 0x300 gets snoop_retry=1 that cycle.
   - Lines 0x100 then 0x200 sent with writeback continuously high.
4. snoop=1, hit_modified=0 in IDLE: writeback, arr_rd_en and snoop_retry stay 0.
5. Assert reset during beat 2: next cycle all outputs 0 and FSM IDLE; a subsequent trigger at 0x400 starts at beat 0.
6. With CACHE_WB_TIMEOUT_EN defined, TIMEOUT_CYC=8, wb_ready=0:
   - wb_err pulses on the 8th stalled cycle, then wb_valid=0 and writeback=0.
   - Without the macro, wb_valid holds indefinitely.

Source files
------------

// File: rtl/cache_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_wb_pkg
// Description : Shared types and default widths for the cache writeback
//               sequencer. The optional wb_ready watchdog is compiled in by
//               defining CACHE_WB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_wb_pkg;

    localparam int CWB_ADDR_W      = 32;
    localparam int CWB_DATA_W      = 64;
    localparam int CWB_LINE_BEATS  = 4;
    localparam int CWB_TIMEOUT_CYC = 256;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } wb_state_e;

    // Pending writeback request; the address field is sized by CWB_ADDR_W,
    // so the sequencer's ADDR_W is expected to match it.
    typedef struct packed {
        logic [CWB_ADDR_W-1:0] addr;
        logic                  valid;
    } wb_req_t;

endpackage : cache_wb_pkg
`default_nettype wire

// File: rtl/cache_wb_pend_buf.sv
`default_nettype none
// ============================================================================
// Module      : cache_wb_pend_buf
// Description : One-entry holding register for a snoop hit-modified that
//               arrives while a line is already being written back.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_wb_pend_buf
    import cache_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [CWB_ADDR_W-1:0] load_addr,
    input  logic                  pop,
    output logic                  full,
    output logic [CWB_ADDR_W-1:0] addr
);

    wb_req_t r_entry;

    // Load has priority; the sequencer never loads and pops in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_entry <= '0;
        end else if (load) begin
            r_entry.addr  <= load_addr;
            r_entry.valid <= 1'b1;
        end else if (pop) begin
            r_entry.valid <= 1'b0;
        end
    end

    assign full = r_entry.valid;
    assign addr = r_entry.addr;

endmodule : cache_wb_pend_buf
`default_nettype wire

// File: rtl/cache_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cache_wb_sequencer
// Description : On a snoop hit to a modified line, reads the line from the
//               data array beat by beat and streams it onto the memory-side
//               writeback bus (valid/ready). Stalls the core while active.
//               Define CACHE_WB_TIMEOUT_EN to enable the wb_ready watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_wb_sequencer
    import cache_wb_pkg::*;
#(
    parameter int ADDR_W      = CWB_ADDR_W,
    parameter int DATA_W      = CWB_DATA_W,
    parameter int LINE_BEATS  = CWB_LINE_BEATS,
    parameter int TIMEOUT_CYC = CWB_TIMEOUT_CYC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          snoop,
    input  logic                          hit_modified,
    input  logic [ADDR_W-1:0]             snoop_addr,
    input  logic                          fetch,
    input  logic                          rd,
    input  logic                          wr,
    output logic                          core_stall,
    output logic                          snoop_retry,
    output logic                          writeback,
    output logic                          arr_rd_en,
    output logic [ADDR_W-1:0]             arr_addr,
    output logic [$clog2(LINE_BEATS)-1:0] arr_beat,
    input  logic [DATA_W-1:0]             arr_rdata,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [ADDR_W-1:0]             wb_addr,
    output logic [DATA_W-1:0]             wb_data,
    output logic                          wb_last,
    output logic                          wb_err
);

    localparam int               BEAT_W = $clog2(LINE_BEATS);
    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    wb_state_e          r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [BEAT_W-1:0]  r_beat;

    logic               w_snoop_hm;
    logic               w_busy;
    logic               w_pend_load;
    logic               w_pend_pop;
    logic               w_pend_full;
    logic [ADDR_W-1:0]  w_pend_addr;

    // Core requests are simply held off by core_stall; their values never
    // influence the sequencer.
    logic               w_unused_core_req;
    assign w_unused_core_req = fetch | rd | wr;

    assign w_snoop_hm  = snoop && hit_modified;
    assign w_busy      = (r_state != S_IDLE);
    // A hit arriving in DONE with an empty buffer is started directly from
    // DONE, so the buffer only ever fills while RD/WAIT/SEND are active.
    assign w_pend_load = w_snoop_hm && w_busy && !w_pend_full && (r_state != S_DONE);
    assign w_pend_pop  = (r_state == S_DONE) && w_pend_full;
    assign snoop_retry = w_snoop_hm && w_busy && w_pend_full;

    assign core_stall  = writeback;
    assign arr_addr    = r_addr;
    assign arr_beat    = r_beat;
    assign wb_addr     = r_addr;

    cache_wb_pend_buf u_pend_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (w_pend_load),
        .load_addr (snoop_addr),
        .pop       (w_pend_pop),
        .full      (w_pend_full),
        .addr      (w_pend_addr)
    );

`ifdef CACHE_WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
`else
    localparam int C_UNUSED_TMO = TIMEOUT_CYC;
`endif

    // Writeback FSM; every bus/array output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_beat    <= '0;
            writeback <= 1'b0;
            arr_rd_en <= 1'b0;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            wb_last   <= 1'b0;
            wb_err    <= 1'b0;
`ifdef CACHE_WB_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
        end else begin
            wb_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_snoop_hm) begin
                        r_addr    <= snoop_addr;
                        r_beat    <= '0;
                        arr_rd_en <= 1'b1;
                        writeback <= 1'b1;
                        r_state   <= S_RD;
                    end
                end
                S_RD: begin
                    arr_rd_en <= 1'b0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    wb_data  <= arr_rdata;
                    wb_last  <= (r_beat == C_LAST_BEAT);
                    wb_valid <= 1'b1;
                    r_state  <= S_SEND;
                end
                S_SEND: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        wb_last  <= 1'b0;
`ifdef CACHE_WB_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                        if (r_beat == C_LAST_BEAT) begin
                            r_beat  <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_beat    <= r_beat + 1'b1;
                            arr_rd_en <= 1'b1;
                            r_state   <= S_RD;
                        end
`ifdef CACHE_WB_TIMEOUT_EN
                    end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        // Bus has stalled too long: abandon the rest of the line.
                        wb_err    <= 1'b1;
                        wb_valid  <= 1'b0;
                        wb_last   <= 1'b0;
                        r_beat    <= '0;
                        r_tmo_cnt <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    // Keep writeback high across back-to-back lines.
                    if (w_pend_full) begin
                        r_addr    <= w_pend_addr;
                        arr_rd_en <= 1'b1;
                        r_state   <= S_RD;
                    end else if (w_snoop_hm) begin
                        r_addr    <= snoop_addr;
                        arr_rd_en <= 1'b1;
                        r_state   <= S_RD;
                    end else begin
                        writeback <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    writeback <= 1'b0;
                    arr_rd_en <= 1'b0;
                    wb_valid  <= 1'b0;
                    wb_last   <= 1'b0;
                end
            endcase
        end
    end

endmodule : cache_wb_sequencer
`default_nettype wire

// File: tb/tb_cache_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_wb_sequencer
// Description : Self-checking bench for cache_wb_sequencer with a beat
//               scoreboard. Define CACHE_WB_TIMEOUT_EN to exercise the
//               watchdog instead of the indefinite-hold case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_wb_sequencer;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          snoop;
    logic          hit_modified;
    logic [AW-1:0] snoop_addr;
    logic          fetch;
    logic          rd;
    logic          wr;
    logic          core_stall;
    logic          snoop_retry;
    logic          writeback;
    logic          arr_rd_en;
    logic [AW-1:0] arr_addr;
    logic [1:0]    arr_beat;
    logic [DW-1:0] arr_rdata;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_last;
    logic          wb_err;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   wb_hi_cnt = 0;

    cache_wb_sequencer #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .LINE_BEATS  (LB),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .snoop        (snoop),
        .hit_modified (hit_modified),
        .snoop_addr   (snoop_addr),
        .fetch        (fetch),
        .rd           (rd),
        .wr           (wr),
        .core_stall   (core_stall),
        .snoop_retry  (snoop_retry),
        .writeback    (writeback),
        .arr_rd_en    (arr_rd_en),
        .arr_addr     (arr_addr),
        .arr_beat     (arr_beat),
        .arr_rdata    (arr_rdata),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_last      (wb_last),
        .wb_err       (wb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
        return {a, 24'hC0FFEE, 6'd0, 2'(b)};
    endfunction

    // Data array model: one-cycle read latency.
    always @(posedge clk) begin
        if (reset) arr_rdata <= '0;
        else if (arr_rd_en) arr_rdata <= beat_data(arr_addr, int'(arr_beat));
    end

    // Bus monitor: stall mirror, handshake stability and scoreboard pops.
    logic          hold_pend = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            n_tests++;
            if (core_stall !== writeback) begin
                n_fail++;
                $display("FAIL stall_mirror: core_stall=%b writeback=%b", core_stall, writeback);
            end
            if (writeback === 1'b1) wb_hi_cnt++;
            if (hold_pend && wb_err !== 1'b1) begin
                n_tests++;
                if (wb_valid !== 1'b1 || wb_addr !== hold_addr || wb_data !== hold_data || wb_last !== hold_last) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%b addr=%h data=%h last=%b, need valid=1 addr=%h data=%h last=%b",
                             wb_valid, wb_addr, wb_data, wb_last, hold_addr, hold_data, hold_last);
                end
            end
            if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: addr=%h data=%h, need no beat", wb_addr, wb_data);
                end else begin
                    e = q.pop_front();
                    if (wb_addr !== e.addr || wb_data !== e.data || wb_last !== e.last) begin
                        n_fail++;
                        $display("FAIL beat: addr=%h data=%h last=%b, need addr=%h data=%h last=%b",
                                 wb_addr, wb_data, wb_last, e.addr, e.data, e.last);
                    end
                end
            end
            hold_pend = (wb_valid === 1'b1) && (wb_ready !== 1'b1);
            hold_addr = wb_addr;
            hold_data = wb_data;
            hold_last = wb_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [AW-1:0] a);
        for (int b = 0; b < LB; b++) q.push_back('{a, beat_data(a, b), (b == LB - 1)});
    endtask

    task automatic trigger(input logic [AW-1:0] a);
        snoop = 1'b1; hit_modified = 1'b1; snoop_addr = a;
        push_line(a);
        tick();
        snoop = 1'b0; hit_modified = 1'b0;
    endtask

    task automatic wait_wb_low(input string name, input int bound);
        int n = 0;
        while (writeback === 1'b1 && n < bound) begin tick(); n++; end
        n_tests++;
        if (writeback !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: writeback=%b after %0d cycles, need 0", name, writeback, n);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (wb_valid !== 1'b1 && n < 30) begin tick(); n++; end
        n_tests++;
        if (wb_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid_timeout: wb_valid=%b, need 1", name, wb_valid);
        end
    endtask

    task automatic wait_rd_beat(input string name, input logic [1:0] beat);
        int n = 0;
        while (!(arr_rd_en === 1'b1 && arr_beat === beat) && n < 40) begin tick(); n++; end
        n_tests++;
        if (!(arr_rd_en === 1'b1 && arr_beat === beat)) begin
            n_fail++;
            $display("FAIL %s_rd_timeout: arr_rd_en=%b arr_beat=%0d, need 1/%0d", name, arr_rd_en, arr_beat, beat);
        end
    endtask

    task automatic check_queue_empty(input string name);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: %0d beats outstanding, need 0", name, q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({writeback, core_stall, snoop_retry, arr_rd_en, wb_valid, wb_last, wb_err} !== 7'b0 ||
            arr_addr !== '0 || arr_beat !== '0 || wb_addr !== '0 || wb_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: wb=%b st=%b rt=%b rd=%b v=%b l=%b e=%b aa=%h ab=%0d wa=%h wd=%h, need all 0",
                     writeback, core_stall, snoop_retry, arr_rd_en, wb_valid, wb_last, wb_err,
                     arr_addr, arr_beat, wb_addr, wb_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_line();
        wb_ready  = 1'b1;
        wb_hi_cnt = 0;
        trigger(32'h100);
        n_tests++;
        if (writeback !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_wb_next: writeback=%b, need 1", writeback);
        end
        wait_wb_low("basic", 60);
        n_tests++;
        if (wb_hi_cnt != 3 * LB + 1) begin
            n_fail++;
            $display("FAIL basic_wb_cycles: %0d, need %0d", wb_hi_cnt, 3 * LB + 1);
        end
        check_queue_empty("basic");
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d;
        wb_ready = 1'b0;
        trigger(32'h180);
        wait_valid("bp0");
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        wait_valid("bp1");
        d = wb_data;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (wb_valid !== 1'b1 || wb_data !== beat_data(32'h180, 1) || wb_data !== d) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d valid=%b data=%h, need 1/%h", i, wb_valid, wb_data, beat_data(32'h180, 1));
            end
            tick();
        end
        wb_ready = 1'b1;
        tick();
        n_tests++;
        if (wb_valid !== 1'b0 || arr_beat !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_accept: valid=%b beat=%0d, need 0/2", wb_valid, arr_beat);
        end
        wait_wb_low("bp", 60);
        check_queue_empty("bp");
    endtask

    task automatic test_back_to_back();
        wb_ready  = 1'b1;
        wb_hi_cnt = 0;
        trigger(32'h100);
        wait_rd_beat("b2b1", 2'd1);
        snoop = 1'b1; hit_modified = 1'b1; snoop_addr = 32'h200;
        #1;
        n_tests++;
        if (snoop_retry !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_buffer_retry: snoop_retry=%b, need 0", snoop_retry);
        end
        push_line(32'h200);
        tick();
        snoop = 1'b0; hit_modified = 1'b0;
        wait_rd_beat("b2b2", 2'd2);
        snoop = 1'b1; hit_modified = 1'b1; snoop_addr = 32'h300;
        #1;
        n_tests++;
        if (snoop_retry !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_full_retry: snoop_retry=%b, need 1", snoop_retry);
        end
        tick();
        snoop = 1'b0; hit_modified = 1'b0;
        wait_wb_low("b2b", 100);
        n_tests++;
        if (wb_hi_cnt != 2 * (3 * LB + 1)) begin
            n_fail++;
            $display("FAIL b2b_wb_continuous: %0d cycles, need %0d", wb_hi_cnt, 2 * (3 * LB + 1));
        end
        check_queue_empty("b2b");
    endtask

    task automatic test_ignore_clean();
        snoop = 1'b1; hit_modified = 1'b0; snoop_addr = 32'h700;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (snoop_retry !== 1'b0 || writeback !== 1'b0 || arr_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_clean: retry=%b wb=%b rd_en=%b, need 0/0/0", snoop_retry, writeback, arr_rd_en);
            end
            tick();
        end
        snoop = 1'b0;
    endtask

    task automatic test_reset_mid_line();
        wb_ready = 1'b1;
        trigger(32'h100);
        wait_rd_beat("rst", 2'd2);
        wb_ready = 1'b0;
        reset    = 1'b1;
        q.delete();
        tick();
        n_tests++;
        if ({writeback, snoop_retry, arr_rd_en, wb_valid, wb_last, wb_err} !== 6'b0 || arr_beat !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: wb=%b rt=%b rd=%b v=%b l=%b e=%b beat=%0d, need all 0",
                     writeback, snoop_retry, arr_rd_en, wb_valid, wb_last, wb_err, arr_beat);
        end
        reset    = 1'b0;
        wb_ready = 1'b1;
        trigger(32'h400);
        n_tests++;
        if (arr_rd_en !== 1'b1 || arr_beat !== 2'd0 || arr_addr !== 32'h400) begin
            n_fail++;
            $display("FAIL rst_restart: rd_en=%b beat=%0d addr=%h, need 1/0/400", arr_rd_en, arr_beat, arr_addr);
        end
        wait_wb_low("rst", 60);
        check_queue_empty("rst");
    endtask

`ifdef CACHE_WB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        wb_ready = 1'b0;
        trigger(32'h600);
        wait_valid("tmo");
        while (wb_valid === 1'b1 && n < 30) begin tick(); n++; end
        n_tests++;
        if (n != 8 || wb_err !== 1'b1 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_abort: stalled=%0d err=%b valid=%b, need 8/1/0", n, wb_err, wb_valid);
        end
        q.delete();
        tick();
        n_tests++;
        if (wb_err !== 1'b0 || writeback !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_after: err=%b wb=%b, need 0/0", wb_err, writeback);
        end
        wb_ready = 1'b1;
    endtask
`else
    task automatic test_timeout();
        wb_ready = 1'b0;
        trigger(32'h600);
        wait_valid("hold");
        for (int i = 0; i < 30; i++) begin
            n_tests++;
            if (wb_valid !== 1'b1 || wb_err !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_forever: cycle %0d valid=%b err=%b, need 1/0", i, wb_valid, wb_err);
            end
            tick();
        end
        wb_ready = 1'b1;
        wait_wb_low("hold", 60);
        check_queue_empty("hold");
    endtask
`endif

    initial begin
        reset = 1'b1; snoop = 1'b0; hit_modified = 1'b0; snoop_addr = '0;
        fetch = 1'b1; rd = 1'b0; wr = 1'b1; wb_ready = 1'b0;
        test_reset();
        test_basic_line();
        test_backpressure();
        test_back_to_back();
        test_ignore_clean();
        test_reset_mid_line();
        test_timeout();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cache_wb_sequencer
`default_nettype wire
